div_nb_seq: RTL and testbench
=============================

# div_nb_seq

Parametrised sequential radix-2 restoring divider, the WIDTH-generic successor to the team's 8-bit divider. It adds a per-operation signed/unsigned mode, signed-overflow detection and a `busy` indication, and keeps the `start`/`fim` handshake and the zero-divisor flag. It sits in the arithmetic datapath as a multi-cycle unit. Callers issue one operation at a time and read held results once `fim` is high.

## Interface
- `WIDTH`, default 8: operand/result width in bits. Legal range is WIDTH ≥ 2.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `start` input, 1 bit: request a division. Sampled only in IDLE.
- `signed_mode` input, 1 bit: 1 = two's-complement operation, 0 = unsigned. Captured with `start`.
- `div1` input, WIDTH bits: dividend. Captured with `start`.
- `div2` input, WIDTH bits: divisor. Captured with `start`.
- `quo` output, WIDTH bits: quotient. Registered and held until the next completion.
- `resto` output, WIDTH bits: remainder. Registered and held.
- `fim` output, 1 bit: result valid. Level signal, high from completion until the next accepted `start`.
- `zero_div` output, 1 bit: the last operation had `div2 == 0`. Held with the results.
- `ovf` output, 1 bit: the last operation was signed MIN/−1. Held with the results.
- `busy` output, 1 bit: an operation is in progress (any state except IDLE).

## Operation
- **States:**
  - IDLE: on `start` = 1, capture the operands and `signed_mode`, clear `fim`/`zero_div`/`ovf`, go to LOAD.
  - LOAD: if `div2` == 0, go to IDLE with the zero-divisor result. Otherwise form magnitudes (two's-complement negate when signed and the MSB is set), record the quotient and remainder signs, load the iteration counter with WIDTH−1, and go to CALC.
  - CALC: one restoring step per cycle. Shift {rem, dq} left by 1, trial-subtract the divisor magnitude over WIDTH+1 bits, and keep the result if it is non-negative with quotient bit 1, else quotient bit 0. After WIDTH steps go to FIX.
  - FIX: apply the signs, write `quo`/`resto`/`ovf`, set `fim`, go to IDLE.
- **Signed rules:**
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
  - `div1 == quo*div2 + resto` always holds for non-zero divisors.
- **Overflow:** signed div1 = −2^(WIDTH−1) with div2 = −1 gives `quo` = −2^(WIDTH−1) (wrapped), `resto` = 0, `ovf` = 1. `ovf` is always 0 in unsigned mode.
- **Zero divisor:** `quo` = all ones, `resto` = `div1` unchanged, `zero_div` = 1, `ovf` = 0, in both modes.
- **Start while busy:** `start` asserted outside IDLE is ignored. Captured operands are not disturbed.
- **Operand changes:** changing `div1`/`div2`/`signed_mode` after capture has no effect on the current operation.
- **Back-to-back starts:** `start` held high continuously starts a new operation each time the FSM returns to IDLE. `fim` is high for exactly the one cycle spent in IDLE.
- **Reset:** on reset, including mid-operation, the next edge gives state IDLE and `quo`, `resto`, `fim`, `zero_div`, `ovf`, `busy` all 0. A partial result is discarded.

## Timing
- `start` is sampled at rising edge t0 while in IDLE. `busy` is 1 after t0.
- **Normal case:** LOAD at t0+1, CALC at edges t0+2 … t0+WIDTH+1, FIX writes at t0+WIDTH+2.
  - `fim` = 1 and `busy` = 0 after edge t0+WIDTH+2.
  - Latency is WIDTH+2 cycles (10 for WIDTH = 8).
- **Zero divisor:** results are written at edge t0+1. `fim` = 1 and `busy` = 0 after that edge, a latency of 1 cycle.
- **Output stability:** `quo`/`resto`/flags change only at a completion edge or at reset. They are stable whenever `fim` = 1.
- **Throughput:** one operation per WIDTH+3 cycles maximum, because of the IDLE cycle.

## Structure
- **Package `div_pkg`:**
  - state enum (IDLE, LOAD, CALC, FIX);
  - function `abs_w` (conditional two's-complement negate);
  - localparam for the counter width, $clog2(WIDTH).
- **Sub-module `div_step`:**
  - combinational, one restoring iteration;
  - inputs: rem, dq, divisor magnitude;
  - outputs: next rem, next dq;
  - WIDTH-parametrised, verified stand-alone.
- **Top:** FSM, counter, operand/sign registers and output registers in `div_nb_seq`.

## Test plan
- Unsigned 100/5 at WIDTH = 8 → `quo` = 20, `resto` = 0, `zero_div` = 0, `ovf` = 0; `fim` high exactly 10 cycles after the `start` edge, `busy` high in between.
- Signed −7/2 (0xF9/0x02) → `quo` = 0xFD (−3), `resto` = 0xFF (−1). Same bits unsigned, 249/2 → `quo` = 124, `resto` = 1.
- 50/0 in each mode → `quo` = 0xFF, `resto` = 50, `zero_div` = 1, `fim` after 1 cycle. A following 0/10 → `quo` = 0, `resto` = 0, `zero_div` cleared.
- Signed 0x80/0xFF (−128/−1) → `quo` = 0x80, `resto` = 0, `ovf` = 1. Unsigned 0x80/0xFF → `quo` = 0, `resto` = 128, `ovf` = 0.
- Start 200/1, pulse `start` with 15/4 at cycle 3, then assert `reset` at cycle 5 of a new 15/4 → the first result is 200 r0 (second `start` ignored). After reset all outputs are 0 and `busy` = 0. A restarted 15/4 → 3 r3.
- Randomised sweep with WIDTH = 5 and 12, both modes, checked against a reference model: `div1 == quo*div2 + resto`, |`resto`| < |`div2`|, and the sign rules hold.

Source files
------------

// File: rtl/div_nb_seq_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and helpers for the sequential radix-2 restoring divider.
//   div_state_e : FSM encoding (IDLE, LOAD, CALC, FIX), also exported on the
//                 divider's debug state port.
//   cnt_width() : iteration counter width for a given operand width.
//   abs_w()     : conditional two's-complement negate on a MAX_W-bit carrier.
//                 Callers zero-extend into MAX_W and truncate back to their own
//                 width. The low bits of the result are then the negation
//                 modulo 2^WIDTH, so one helper serves every divider width.
// No ports (package).
// -----------------------------------------------------------------------------
package div_pkg;

    // Widest operand the abs_w carrier supports.
    localparam int MAX_W = 64;

    localparam int DEFAULT_WIDTH = 8;

    // Counter width for the default operand width.
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } div_state_e;

    // The counter holds WIDTH-1 down to 0, so $clog2(WIDTH) bits are enough.
    // WIDTH = 2 still needs one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] value,
                                               input logic             negate);
        return negate ? ((~value) + {{(MAX_W-1){1'b0}}, 1'b1}) : value;
    endfunction

endpackage

// File: rtl/div_nb_seq_if.sv
// -----------------------------------------------------------------------------
// div_nb_seq_if
// Request/result bundle between a caller and the sequential divider.
//
// Handshake
//   The caller raises start together with div1, div2 and signed_mode.
//   The divider samples start only while idle. The operands and the mode are
//   captured on that same edge, and the caller may change them afterwards.
//   busy is high from the accepting edge until the completion edge.
//   fim rises on the completion edge. It stays high, with quo, resto,
//   zero_div and ovf held stable, until the next start is accepted.
//   A start seen while busy is dropped; it is not queued.
//
// Signals (master = caller, slave = divider)
//   start, signed_mode, div1[WIDTH], div2[WIDTH]        : master -> slave
//   quo[WIDTH], resto[WIDTH], fim, zero_div, ovf, busy  : slave  -> master
// -----------------------------------------------------------------------------
interface div_nb_seq_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] div1;
    logic [WIDTH-1:0] div2;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] resto;
    logic             fim;
    logic             zero_div;
    logic             ovf;
    logic             busy;

    modport master (
        output start, signed_mode, div1, div2,
        input  quo, resto, fim, zero_div, ovf, busy
    );

    modport slave (
        input  start, signed_mode, div1, div2,
        output quo, resto, fim, zero_div, ovf, busy
    );

endinterface

// File: rtl/div_nb_seq_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration on unsigned magnitudes.
//   rem_i[WIDTH]  : partial remainder (always < dmag_i)
//   dq_i[WIDTH]   : dividend bits still to consume (MSB first) with quotient
//                   bits shifted in at the LSB
//   dmag_i[WIDTH] : divisor magnitude (non-zero)
//   rem_o[WIDTH]  : next partial remainder
//   dq_o[WIDTH]   : next dividend/quotient register
// {rem, dq} is shifted left by one and the divisor is trial-subtracted over
// WIDTH+1 bits. A clear borrow bit keeps the difference and shifts in a
// quotient 1; otherwise the shifted remainder is restored and a 0 goes in.
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dq_i,
    input  logic [WIDTH-1:0] dmag_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dq_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem_i, dq_i[WIDTH-1]};
        trial   = shifted - {1'b0, dmag_i};
        // rem_i < dmag_i, so shifted < 2*dmag_i. A non-negative difference
        // therefore fits in WIDTH bits, and the restored value also fits.
        if (!trial[WIDTH]) begin
            rem_o = trial[WIDTH-1:0];
            dq_o  = {dq_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            dq_o  = {dq_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_nb_seq.sv
// -----------------------------------------------------------------------------
// div_nb_seq
// Multi-cycle radix-2 restoring divider with an unsigned or two's-complement
// mode selected per operation.
//   clk      : rising-edge clock
//   reset    : synchronous, active-high; discards any operation in flight
//   bus      : div_nb_seq_if.slave (start/operands in, results/flags out)
//   state_o  : current FSM state, for observation only
// Latency is WIDTH+2 cycles from the accepting edge, or 1 cycle for a zero
// divisor. The quotient truncates toward zero and the remainder carries the
// dividend's sign. Signed MIN / -1 wraps to MIN with remainder 0 and raises ovf.
// -----------------------------------------------------------------------------
module div_nb_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
    div_nb_seq_if.slave bus,
    output div_state_e  state_o
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;

    // Captured request
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sm_q;

    // Iteration datapath
    logic [WIDTH-1:0] bmag_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dq_q;
    logic             qneg_q;
    logic             rneg_q;

    // Result registers
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] resto_q;
    logic             fim_q;
    logic             zdiv_q;
    logic             ovf_q;
    logic             busy_q;

    // Next-state values computed from the registers
    logic             a_neg_d;
    logic             b_neg_d;
    logic [WIDTH-1:0] amag_d;
    logic [WIDTH-1:0] bmag_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] dq_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] resto_d;
    logic             ovf_d;

    always_comb begin
        a_neg_d = sm_q & a_q[WIDTH-1];
        b_neg_d = sm_q & b_q[WIDTH-1];
        amag_d  = WIDTH'(abs_w(MAX_W'(a_q), a_neg_d));
        bmag_d  = WIDTH'(abs_w(MAX_W'(b_q), b_neg_d));
        quo_d   = WIDTH'(abs_w(MAX_W'(dq_q), qneg_q));
        resto_d = WIDTH'(abs_w(MAX_W'(rem_q), rneg_q));
        // MIN / -1 needs no special datapath. The magnitude quotient 2^(W-1)
        // with a positive sign already wraps to MIN. Only the flag is added.
        ovf_d   = sm_q & (a_q == MIN_VAL) & (b_q == {WIDTH{1'b1}});
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .dq_i   (dq_q),
        .dmag_i (bmag_q),
        .rem_o  (rem_d),
        .dq_o   (dq_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            bmag_q  <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quo_q   <= '0;
            resto_q <= '0;
            fim_q   <= 1'b0;
            zdiv_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.div1;
                        b_q     <= bus.div2;
                        sm_q    <= bus.signed_mode;
                        fim_q   <= 1'b0;
                        zdiv_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end

                LOAD: begin
                    if (b_q == '0) begin
                        quo_q   <= {WIDTH{1'b1}};
                        resto_q <= a_q;
                        zdiv_q  <= 1'b1;
                        ovf_q   <= 1'b0;
                        fim_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        bmag_q  <= bmag_d;
                        rem_q   <= '0;
                        dq_q    <= amag_d;
                        qneg_q  <= a_neg_d ^ b_neg_d;
                        rneg_q  <= a_neg_d;
                        cnt_q   <= CNT_W'(WIDTH - 1);
                        state_q <= CALC;
                    end
                end

                CALC: begin
                    rem_q <= rem_d;
                    dq_q  <= dq_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    // Entered with WIDTH-1, so the cycle that sees 0 is step WIDTH.
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end

                FIX: begin
                    quo_q   <= quo_d;
                    resto_q <= resto_d;
                    ovf_q   <= ovf_d;
                    fim_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.quo      = quo_q;
    assign bus.resto    = resto_q;
    assign bus.fim      = fim_q;
    assign bus.zero_div = zdiv_q;
    assign bus.ovf      = ovf_q;
    assign bus.busy     = busy_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_div_nb_seq.sv
// -----------------------------------------------------------------------------
// tb_div_nb_seq
// Directed scenarios on an 8-bit instance, plus randomized sweeps on 5-bit and
// 12-bit instances checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_div_nb_seq;
    import div_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8;
    div_state_e st8;
    div_nb_seq_if #(.WIDTH(8)) if8 ();

    div_nb_seq #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .reset   (rst8),
        .bus     (if8.slave),
        .state_o (st8)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void ref_div(input int w, input longint unsigned a, input longint unsigned b,
                                    input bit sm, output longint unsigned q, output longint unsigned r,
                                    output bit z, output bit o);
        longint unsigned mask;
        longint          sa, sb;
        mask = (64'd1 << w) - 64'd1;
        z = 1'b0;
        o = 1'b0;
        if (b == 0) begin
            q = mask;
            r = a;
            z = 1'b1;
        end else if (!sm) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'(a) - (a[w-1] ? longint'(64'd1 << w) : 64'sd0);
            sb = longint'(b) - (b[w-1] ? longint'(64'd1 << w) : 64'sd0);
            if (sa == -(64'sd1 <<< (w - 1)) && sb == -64'sd1) begin
                q = longint'(sa) & mask;
                r = 0;
                o = 1'b1;
            end else begin
                q = longint'(sa / sb) & mask;
                r = longint'(sa % sb) & mask;
            end
        end
    endfunction

    // ---------------- 8-bit driver tasks ----------------
    // Waits for fim with a cycle budget; lat counts edges after the entry point.
    task automatic wait_fim8(input string tag, output int lat);
        bit busy_gap;
        lat      = 0;
        busy_gap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (if8.fim) break;
            if (!if8.busy) busy_gap = 1'b1;
        end
        check({tag, "_busy_between"}, 64'(busy_gap), 64'd0);
        if (!if8.fim) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Issues one operation from a point 1 ns after an edge and checks the result.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input bit sm,
                       input logic [7:0] eq, input logic [7:0] er, input bit ez, input bit eo);
        int lat;
        if8.start       = 1'b1;
        if8.div1        = a;
        if8.div2        = b;
        if8.signed_mode = sm;
        @(posedge clk);
        #1;
        if8.start       = 1'b0;
        // Captured operands must not follow later input changes.
        if8.div1        = 8'($urandom);
        if8.div2        = 8'($urandom);
        if8.signed_mode = 1'($urandom);
        check({tag, "_busy_t0"}, 64'(if8.busy), 64'd1);
        check({tag, "_fim_t0"}, 64'(if8.fim), 64'd0);
        check({tag, "_zdiv_t0"}, 64'(if8.zero_div), 64'd0);
        wait_fim8(tag, lat);
        check({tag, "_lat"}, 64'(lat), ez ? 64'd1 : 64'd10);
        check({tag, "_quo"}, 64'(if8.quo), 64'(eq));
        check({tag, "_resto"}, 64'(if8.resto), 64'(er));
        check({tag, "_zdiv"}, 64'(if8.zero_div), 64'(ez));
        check({tag, "_ovf"}, 64'(if8.ovf), 64'(eo));
        check({tag, "_busy_done"}, 64'(if8.busy), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_hold_fim"}, 64'(if8.fim), 64'd1);
        check({tag, "_hold_quo"}, 64'(if8.quo), 64'(eq));
    endtask

    // ---------------- randomized sweeps, WIDTH = 5 and 12 ----------------
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int W = (g == 0) ? 5 : 12;
        logic            rst;
        div_state_e      st;
        bit              done_f = 1'b0;
        logic [W-1:0]    a, b;
        bit              sm;
        div_nb_seq_if #(.WIDTH(W)) sif ();

        div_nb_seq #(.WIDTH(W)) dut (
            .clk     (clk),
            .reset   (rst),
            .bus     (sif.slave),
            .state_o (st)
        );

        initial begin
            longint unsigned q_e, r_e;
            bit              z_e, o_e;
            int              lat;
            string           tg;
            rst             = 1'b1;
            sif.start       = 1'b0;
            sif.signed_mode = 1'b0;
            sif.div1        = '0;
            sif.div2        = '0;
            repeat (3) @(posedge clk);
            #1;
            tg = $sformatf("w%0d_reset", W);
            check({tg, "_busy"}, 64'(sif.busy), 64'd0);
            check({tg, "_fim"}, 64'(sif.fim), 64'd0);
            rst = 1'b0;
            for (int n = 0; n < 300; n++) begin
                a  = W'($urandom);
                b  = W'($urandom);
                sm = 1'($urandom);
                case ($urandom_range(0, 9))
                    0: b = '0;
                    1: begin a = {1'b1, {(W-1){1'b0}}}; b = '1; sm = 1'b1; end
                    2: b = W'(1);
                    3: b = '1;
                    default: ;
                endcase
                ref_div(W, 64'(a), 64'(b), sm, q_e, r_e, z_e, o_e);
                tg = $sformatf("w%0d_op%0d", W, n);
                sif.start       = 1'b1;
                sif.div1        = a;
                sif.div2        = b;
                sif.signed_mode = sm;
                @(posedge clk);
                #1;
                sif.start       = 1'b0;
                sif.div1        = W'($urandom);
                sif.div2        = W'($urandom);
                sif.signed_mode = 1'($urandom);
                lat = 0;
                for (int i = 0; i < W + 10; i++) begin
                    @(posedge clk);
                    #1;
                    lat++;
                    if (sif.fim) break;
                end
                check({tg, "_lat"}, 64'(lat), z_e ? 64'd1 : 64'(W + 2));
                check({tg, "_quo"}, 64'(sif.quo), q_e);
                check({tg, "_resto"}, 64'(sif.resto), r_e);
                check({tg, "_zdiv"}, 64'(sif.zero_div), 64'(z_e));
                check({tg, "_ovf"}, 64'(sif.ovf), 64'(o_e));
                if (b != '0) begin
                    // div1 == quo*div2 + resto modulo 2^W in both modes.
                    check({tg, "_ident"}, 64'(W'(a - (sif.quo * b + sif.resto))), 64'd0);
                end
                @(posedge clk);
                #1;
            end
            done_f = 1'b1;
        end
    end

    // ---------------- directed 8-bit scenarios ----------------
    initial begin
        int lat;
        rst8            = 1'b1;
        if8.start       = 1'b0;
        if8.signed_mode = 1'b0;
        if8.div1        = '0;
        if8.div2        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_quo", 64'(if8.quo), 64'd0);
        check("rst_resto", 64'(if8.resto), 64'd0);
        check("rst_fim", 64'(if8.fim), 64'd0);
        check("rst_busy", 64'(if8.busy), 64'd0);
        check("rst_state", 64'(st8), 64'(IDLE));
        rst8 = 1'b0;

        op8("u100_5",  8'd100, 8'd5,    1'b0, 8'd20,  8'd0,   1'b0, 1'b0);
        op8("s_m7_2",  8'hF9,  8'h02,   1'b1, 8'hFD,  8'hFF,  1'b0, 1'b0);
        op8("u249_2",  8'hF9,  8'h02,   1'b0, 8'd124, 8'd1,   1'b0, 1'b0);
        op8("u50_0",   8'd50,  8'd0,    1'b0, 8'hFF,  8'd50,  1'b1, 1'b0);
        op8("s50_0",   8'd50,  8'd0,    1'b1, 8'hFF,  8'd50,  1'b1, 1'b0);
        op8("u0_10",   8'd0,   8'd10,   1'b0, 8'd0,   8'd0,   1'b0, 1'b0);
        op8("s_ovf",   8'h80,  8'hFF,   1'b1, 8'h80,  8'd0,   1'b0, 1'b1);
        op8("u80_ff",  8'h80,  8'hFF,   1'b0, 8'd0,   8'd128, 1'b0, 1'b0);
        op8("s_m100_7", 8'h9C, 8'h07,   1'b1, 8'hF2,  8'hFE,  1'b0, 1'b0);

        // Start while busy is ignored.
        if8.start = 1'b1; if8.div1 = 8'd200; if8.div2 = 8'd1; if8.signed_mode = 1'b0;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        if8.start = 1'b1; if8.div1 = 8'd15; if8.div2 = 8'd4;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        wait_fim8("ign", lat);
        check("ign_lat", 64'(lat + 3), 64'd10);
        check("ign_quo", 64'(if8.quo), 64'd200);
        check("ign_resto", 64'(if8.resto), 64'd0);

        // Reset in the middle of an operation.
        @(posedge clk);
        #1;
        if8.start = 1'b1; if8.div1 = 8'd15; if8.div2 = 8'd4;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst8 = 1'b1;
        @(posedge clk);
        #1;
        rst8 = 1'b0;
        check("mrst_quo", 64'(if8.quo), 64'd0);
        check("mrst_resto", 64'(if8.resto), 64'd0);
        check("mrst_fim", 64'(if8.fim), 64'd0);
        check("mrst_zdiv", 64'(if8.zero_div), 64'd0);
        check("mrst_ovf", 64'(if8.ovf), 64'd0);
        check("mrst_busy", 64'(if8.busy), 64'd0);
        check("mrst_state", 64'(st8), 64'(IDLE));
        op8("u15_4", 8'd15, 8'd4, 1'b0, 8'd3, 8'd3, 1'b0, 1'b0);

        // Back-to-back: start held high relaunches from the single IDLE cycle.
        if8.start = 1'b1; if8.div1 = 8'd20; if8.div2 = 8'd3; if8.signed_mode = 1'b0;
        @(posedge clk);
        #1;
        wait_fim8("b2b1", lat);
        check("b2b1_quo", 64'(if8.quo), 64'd6);
        check("b2b1_resto", 64'(if8.resto), 64'd2);
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        check("b2b_fim_one_cycle", 64'(if8.fim), 64'd0);
        check("b2b_busy_again", 64'(if8.busy), 64'd1);
        wait_fim8("b2b2", lat);
        check("b2b2_lat", 64'(lat), 64'd10);
        check("b2b2_quo", 64'(if8.quo), 64'd6);
        check("b2b2_resto", 64'(if8.resto), 64'd2);

        for (int i = 0; i < 20000 && !(g_sweep[0].done_f && g_sweep[1].done_f); i++) begin
            @(posedge clk);
        end
        check("sweeps_done", 64'(g_sweep[0].done_f && g_sweep[1].done_f), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
